// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, runtime divisor, parity and 1/2 stop bits
// Line outputs are registered from the current state, so the line trails the FSM by one cycle.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_L,
  input  logic [DIV_W-1:0]         i_Clks_Per_Bit,
  input  logic [1:0]               i_Parity_Mode,
  input  logic                     i_Two_Stop,
  input  logic                     i_Tx_Valid,
  input  logic [DATA_W-1:0]        i_Tx_Data,
  output logic                     o_Tx_Ready,
  output logic [$clog2(DEPTH):0]   o_Fifo_Count,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Active,
  output logic                     o_Tx_Done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_count;
  logic [DIV_W-1:0]    r_div, r_clk_cnt, r_bit_cnt;
  logic [1:0]          r_par;
  logic                r_two;
  logic [DATA_W-1:0]   r_data, r_shift;
  logic                r_serial, r_active, r_end, r_done;
  logic                w_push, w_pop, w_empty, w_bit_end, w_line;

  assign w_empty      = (r_count == '0);
  assign o_Tx_Ready   = (r_count != (AW+1)'(DEPTH));
  assign w_push       = i_Tx_Valid && o_Tx_Ready;
  assign w_bit_end    = (r_clk_cnt == r_div - DIV_ONE);
  assign o_Fifo_Count = r_count;
  assign o_Tx_Serial  = r_serial;
  assign o_Tx_Active  = r_active;
  assign o_Tx_Done    = r_done;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_line = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next = S_START;
          w_pop  = 1'b1;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_bit_end && r_bit_cnt == DIV_W'(DATA_W-1))
          w_next = (r_par == 2'b00) ? S_STOP : S_PARITY;
      end
      S_PARITY: begin
        case (r_par)
          2'b01:   w_line = ^r_data;
          2'b10:   w_line = ~^r_data;
          default: w_line = 1'b1;
        endcase
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        // Successor frame starts straight out of STOP so the line has no idle gap.
        if (w_bit_end && r_bit_cnt == (r_two ? DIV_ONE : '0)) begin
          if (!w_empty) begin
            w_next = S_START;
            w_pop  = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_Tx_Data;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_div     <= DIV_ONE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_par     <= 2'b00;
      r_two     <= 1'b0;
      r_data    <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_end     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE || w_bit_end) r_clk_cnt <= '0;
      else                                r_clk_cnt <= r_clk_cnt + DIV_ONE;

      if (w_next != r_state) r_bit_cnt <= '0;
      else if (w_bit_end)    r_bit_cnt <= r_bit_cnt + DIV_ONE;

      if (w_pop) begin
        r_data   <= r_mem[r_rd_ptr];
        r_shift  <= r_mem[r_rd_ptr];
        r_div    <= (i_Clks_Per_Bit == '0) ? DIV_ONE : i_Clks_Per_Bit;
        r_par    <= i_Parity_Mode;
        r_two    <= i_Two_Stop;
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift  <= r_shift >> 1;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      // Done is delayed twice so it lands in the cycle after the last stop bit on the line.
      r_serial <= w_line;
      r_active <= (r_state != S_IDLE);
      r_end    <= (r_state == S_STOP) && (w_next != S_STOP);
      r_done   <= r_end;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a per-cycle line model
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpb;
  logic [1:0]  pmode;
  logic        two_stop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [2:0]  fifo_count;
  logic        tx_serial, tx_active, tx_done;
  logic        u5_valid;
  logic [4:0]  u5_data;
  logic        u5_ready;
  logic [2:0]  u5_count;
  logic        u5_serial, u5_active, u5_done;

  int vectors = 0;
  int miscompares = 0;
  bit eq_ser[$], eq_act[$], eq_done[$];
  bit pend_done = 1'b0;
  bit e_ser, e_act, e_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .DIV_W(16), .DEPTH(4)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Clks_Per_Bit(cpb), .i_Parity_Mode(pmode),
    .i_Two_Stop(two_stop), .i_Tx_Valid(tx_valid), .i_Tx_Data(tx_data),
    .o_Tx_Ready(tx_ready), .o_Fifo_Count(fifo_count), .o_Tx_Serial(tx_serial),
    .o_Tx_Active(tx_active), .o_Tx_Done(tx_done));

  uart_tx_fifo #(.DATA_W(5), .DIV_W(16), .DEPTH(4)) dut5 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Clks_Per_Bit(16'd0), .i_Parity_Mode(2'b00),
    .i_Two_Stop(1'b0), .i_Tx_Valid(u5_valid), .i_Tx_Data(u5_data),
    .o_Tx_Ready(u5_ready), .o_Fifo_Count(u5_count), .o_Tx_Serial(u5_serial),
    .o_Tx_Active(u5_active), .o_Tx_Done(u5_done));

  // Model: expand each character into per-cycle (line, active, done) expectations.
  task automatic add_frame(input logic [8:0] d, input int n, input logic [1:0] mode,
                           input bit two, input int dw);
    bit b[$];
    bit par;
    int nn;
    nn  = (n == 0) ? 1 : n;
    par = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      b.push_back(d[i]);
      par ^= d[i];
    end
    if (mode == 2'b01)      b.push_back(par);
    else if (mode == 2'b10) b.push_back(~par);
    else if (mode == 2'b11) b.push_back(1'b1);
    b.push_back(1'b1);
    if (two) b.push_back(1'b1);
    foreach (b[i]) begin
      for (int j = 0; j < nn; j++) begin
        eq_ser.push_back(b[i]);
        eq_act.push_back(1'b1);
        eq_done.push_back(pend_done);
        pend_done = 1'b0;
      end
    end
    pend_done = 1'b1;
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) begin
      eq_ser.push_back(1'b1);
      eq_act.push_back(1'b0);
      eq_done.push_back(pend_done);
      pend_done = 1'b0;
    end
  endtask

  task automatic next_exp();
    if (eq_ser.size() == 0) begin
      e_ser = 1'b1; e_act = 1'b0; e_done = 1'b0;
    end else begin
      e_ser  = eq_ser.pop_front();
      e_act  = eq_act.pop_front();
      e_done = eq_done.pop_front();
    end
  endtask

  task automatic clear_model();
    eq_ser.delete(); eq_act.delete(); eq_done.delete();
    pend_done = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpb = 16'd4; pmode = 2'b00; two_stop = 1'b0;
    tx_valid = 1'b0; tx_data = '0; u5_valid = 1'b0; u5_data = '0;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL reset_serial: got %b expected 1", tx_serial); end
    if (tx_active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b expected 0", tx_active); end
    if (tx_done !== 1'b0)   begin miscompares++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    if (tx_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    if (u5_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_u5_ready: got %b expected 1", u5_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    int cyc, done_cnt, done_at;
    clear_model();
    add_frame(9'h055, 4, 2'b00, 1'b0, 8);
    add_idle(4);
    push_char(8'h55);
    vectors += 4;
    if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL lat_count_t: got %0d expected 1", fifo_count); end
    @(negedge clk);
    if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL lat_count_t1: got %0d expected 0", fifo_count); end
    if (tx_serial !== 1'b1)  begin miscompares++; $display("FAIL lat_serial_t1: got %b expected 1", tx_serial); end
    if (tx_active !== 1'b0)  begin miscompares++; $display("FAIL lat_active_t1: got %b expected 0", tx_active); end
    @(negedge clk);
    cyc = 0; done_cnt = 0; done_at = -1;
    while (eq_ser.size() > 0) begin
      next_exp();
      vectors++;
      if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
        miscompares++;
        $display("FAIL 8n1_line cyc %0d: got %b%b%b expected %b%b%b", cyc, tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
      end
      if (tx_done) begin done_cnt++; done_at = cyc; end
      cyc++;
      @(negedge clk);
    end
    vectors += 2;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL 8n1_done_count: got %0d expected 1", done_cnt); end
    if (done_at !== 40) begin miscompares++; $display("FAIL 8n1_done_cycle: got %0d expected 40", done_at); end
  endtask

  task automatic test_parity();
    logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [7:0] datas [4] = '{8'h07, 8'h03, 8'h00, 8'hFF};
    bit         twos  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int cyc, act_cnt;
    for (int c = 0; c < 4; c++) begin
      clear_model();
      pmode = modes[c]; two_stop = twos[c]; cpb = 16'd4;
      add_frame({1'b0, datas[c]}, 4, modes[c], twos[c], 8);
      add_idle(3);
      push_char(datas[c]);
      @(negedge clk);
      @(negedge clk);
      cyc = 0; act_cnt = 0;
      while (eq_ser.size() > 0) begin
        next_exp();
        vectors++;
        if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
          miscompares++;
          $display("FAIL parity_line case %0d cyc %0d: got %b%b%b expected %b%b%b", c, cyc, tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
        end
        if (c < 3 && cyc == 37) begin
          vectors++;
          if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL parity_bit case %0d: got %b expected 1", c, tx_serial); end
        end
        if (tx_active) act_cnt++;
        cyc++;
        @(negedge clk);
      end
      vectors++;
      if (act_cnt !== 44) begin miscompares++; $display("FAIL parity_frame_len case %0d: got %0d expected 44", c, act_cnt); end
    end
    pmode = 2'b00; two_stop = 1'b0;
  endtask

  task automatic test_fifo_fill();
    int acc, done_cnt, gap;
    bit w, exp_rdy;
    clear_model();
    cpb = 16'd8;
    for (int i = 0; i < 5; i++) add_frame(9'(8'hA1 + i), 8, 2'b00, 1'b0, 8);
    add_idle(3);
    tx_data = 8'hA1; tx_valid = 1'b1;
    acc = 0; done_cnt = 0; gap = 0;
    for (int k = 0; k < 405; k++) begin
      w = tx_valid && tx_ready;
      @(negedge clk);
      if (w) begin acc++; tx_data = tx_data + 8'd1; end
      if (k >= 2) begin
        next_exp();
        vectors++;
        if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
          miscompares++;
          $display("FAIL fill_line k %0d: got %b%b%b expected %b%b%b", k, tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
        end
        if (tx_done) done_cnt++;
        if (k < 402 && !tx_active) gap++;
      end
      if (k <= 81) begin
        exp_rdy = (k <= 3) || (k == 81);
        vectors++;
        if (tx_ready !== exp_rdy) begin miscompares++; $display("FAIL fill_ready k %0d: got %b expected %b", k, tx_ready, exp_rdy); end
      end
      if (k == 81) begin
        tx_valid = 1'b0;
        vectors++;
        if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL fill_count_after_pop: got %0d expected 3", fifo_count); end
      end
    end
    vectors += 3;
    if (acc !== 5)      begin miscompares++; $display("FAIL fill_accepted: got %0d expected 5", acc); end
    if (done_cnt !== 5) begin miscompares++; $display("FAIL fill_done_pulses: got %0d expected 5", done_cnt); end
    if (gap !== 0)      begin miscompares++; $display("FAIL fill_active_gap: got %0d expected 0", gap); end
    cpb = 16'd4;
  endtask

  task automatic test_div_change();
    logic [7:0] d2;
    int cyc;
    clear_model();
    d2 = 8'($urandom);
    cpb = 16'd4;
    add_frame(9'h03C, 4, 2'b00, 1'b0, 8);
    add_frame({1'b0, d2}, 6, 2'b00, 1'b0, 8);
    add_idle(3);
    push_char(8'h3C);
    push_char(d2);
    @(negedge clk);
    cyc = 0;
    while (eq_ser.size() > 0) begin
      if (cyc == 20) cpb = 16'd6;
      next_exp();
      vectors++;
      if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
        miscompares++;
        $display("FAIL divchg_line cyc %0d: got %b%b%b expected %b%b%b", cyc, tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
      end
      cyc++;
      @(negedge clk);
    end
    cpb = 16'd4;
  endtask

  task automatic test_reset_mid();
    logic [7:0] fresh;
    clear_model();
    cpb = 16'd4;
    add_frame(9'h081, 4, 2'b00, 1'b0, 8);
    push_char(8'h81);
    push_char(8'($urandom));
    push_char(8'($urandom));
    for (int cyc = 0; cyc < 17; cyc++) begin
      next_exp();
      vectors++;
      if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
        miscompares++;
        $display("FAIL rstmid_pre cyc %0d: got %b%b%b expected %b%b%b", cyc, tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (tx_serial !== 1'b1)  begin miscompares++; $display("FAIL rstmid_serial: got %b expected 1", tx_serial); end
    if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
    if (tx_active !== 1'b0)  begin miscompares++; $display("FAIL rstmid_active: got %b expected 0", tx_active); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      vectors++;
      if ({tx_serial, tx_active, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
        miscompares++;
        $display("FAIL rstmid_quiet cyc %0d: got %b%b%0d expected 1 0 0", cyc, tx_serial, tx_active, fifo_count);
      end
    end
    fresh = 8'($urandom);
    add_frame({1'b0, fresh}, 4, 2'b00, 1'b0, 8);
    add_idle(3);
    push_char(fresh);
    @(negedge clk);
    @(negedge clk);
    while (eq_ser.size() > 0) begin
      next_exp();
      vectors++;
      if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
        miscompares++;
        $display("FAIL rstmid_fresh: got %b%b%b expected %b%b%b", tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div0_w5();
    int act_cnt;
    clear_model();
    add_frame(9'h015, 0, 2'b00, 1'b0, 5);
    add_idle(3);
    u5_data = 5'h15; u5_valid = 1'b1;
    @(negedge clk);
    u5_valid = 1'b0;
    vectors++;
    if (u5_count !== 3'd1) begin miscompares++; $display("FAIL div0_count: got %0d expected 1", u5_count); end
    @(negedge clk);
    @(negedge clk);
    act_cnt = 0;
    while (eq_ser.size() > 0) begin
      next_exp();
      vectors++;
      if ({u5_serial, u5_active, u5_done} !== {e_ser, e_act, e_done}) begin
        miscompares++;
        $display("FAIL div0_line: got %b%b%b expected %b%b%b", u5_serial, u5_active, u5_done, e_ser, e_act, e_done);
      end
      if (u5_active) act_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (act_cnt !== 7) begin miscompares++; $display("FAIL div0_frame_len: got %0d expected 7", act_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] d [3];
    int n, k;
    logic [1:0] mode;
    bit two;
    for (int it = 0; it < 8; it++) begin
      clear_model();
      n = $urandom_range(0, 5);
      mode = 2'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 3);
      cpb = 16'(n); pmode = mode; two_stop = two;
      for (int i = 0; i < k; i++) begin
        d[i] = 8'($urandom);
        add_frame({1'b0, d[i]}, n, mode, two, 8);
      end
      add_idle(3);
      for (int i = 0; i < k; i++) push_char(d[i]);
      repeat (3 - k) @(negedge clk);
      while (eq_ser.size() > 0) begin
        next_exp();
        vectors++;
        if ({tx_serial, tx_active, tx_done} !== {e_ser, e_act, e_done}) begin
          miscompares++;
          $display("FAIL random it %0d n %0d mode %0d two %0d: got %b%b%b expected %b%b%b", it, n, mode, two, tx_serial, tx_active, tx_done, e_ser, e_act, e_done);
        end
        @(negedge clk);
      end
    end
    cpb = 16'd4; pmode = 2'b00; two_stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_fifo_fill();
    test_div_change();
    test_reset_mid();
    test_div0_w5();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, runtime baud divisor, selectable parity and one or two stop bits. It replaces the fixed 8N1 transmitter on the board's serial link. Upstream logic can queue several characters through a valid/ready handshake, and the block then sends them as contiguous frames with no idle gap between them.

## Interface
- DATA_W, 8: data bits per frame, legal 5..9.
- DIV_W, 16: width of the baud divisor.
- DEPTH, 4: FIFO entries, a power of two of at least 2.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Clks_Per_Bit  in  DIV_W  clocks per bit N; 0 is treated as 1.
- i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 mark (always 1).
- i_Two_Stop  in  1  1 selects two stop bits.
- i_Tx_Valid  in  1  write request.
- i_Tx_Data  in  DATA_W  character to send.
- o_Tx_Ready  out  1  FIFO not full.
- o_Fifo_Count  out  $clog2(DEPTH)+1  number of FIFO entries.
- o_Tx_Serial  out  1  serial line, registered, idles high.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Push: a write happens on any edge where i_Tx_Valid and o_Tx_Ready are both high. A write while full is impossible because o_Tx_Ready = !full.
- Pop: the FSM pops the FIFO head into the shift register on entering START.
- A push and a pop on the same edge leave the count unchanged.
- Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty.
  - START -> DATA after N cycles.
  - DATA -> PARITY or STOP after DATA_W bits, each N cycles long.
  - PARITY -> STOP after N cycles. PARITY is skipped when mode is 00.
  - STOP lasts N cycles, or 2N cycles when two stop bits are selected.
  - At the end of STOP: FIFO non-empty -> START (pop on the same edge), otherwise IDLE.
- Line levels per state:
  - START: 0.
  - DATA: data bits LSB first.
  - PARITY: even = XOR of the data bits, odd = its inverse, mark = 1.
  - STOP and IDLE: 1.
- Configuration latch: i_Clks_Per_Bit, i_Parity_Mode and i_Two_Stop are captured on entering START and held for the whole frame. Changes mid-frame affect only the next frame.
- Bit counter and divisor counter are DIV_W bits wide. The divisor counter counts 0..N-1 and reloads to 0 at each bit boundary.
- Frame length is exactly N*(1 + DATA_W + P + S) cycles, where P is 0 or 1 and S is 1 or 2.
- o_Tx_Active rises with the start bit and falls on the edge that ends the last stop bit of a frame that has no successor.
- Reset (asynchronous, anytime, including mid-frame):
  - FIFO emptied, FSM to IDLE.
  - o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Ready = 1, o_Fifo_Count = 0.
  - After reset release, no partial frame resumes.

## Timing
- First-character latency: write at edge t with the FIFO empty and the FSM in IDLE.
  - o_Fifo_Count = 1 after edge t.
  - Pop at edge t+1.
  - o_Tx_Serial low and o_Tx_Active high from edge t+2.
- o_Tx_Done is high for exactly the one cycle following the final stop-bit cycle of every frame, including back-to-back frames.
- Back-to-back frames: the next start bit begins on the cycle immediately after the final stop-bit cycle. There are zero idle cycles, and o_Tx_Active stays high.
- With N = 1, every bit lasts one cycle. No other special cases.
- o_Tx_Ready and o_Fifo_Count update on the edge after a push or pop (registered).

## Test plan
- Plain 8N1 frame: DATA_W=8, N=4, mode 00, one stop bit; write 0x55 from idle.
  - Line low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - Frame is 40 cycles; o_Tx_Done pulses once at cycle 40 after the start bit.
- Parity and stop bits, N=4:
  - Even parity, write 0x07: parity bit = 1.
  - Odd parity, write 0x03: parity bit = 1.
  - Mark parity, write 0x00: parity bit = 1.
  - Two stop bits, write 0xFF, no parity: line high for 8 cycles before idle or the next start; frame is 44 cycles.
- FIFO fill: DEPTH=4, N=8; hold i_Tx_Valid high with data 0xA1, 0xA2, ... every cycle.
  - Exactly 5 characters accepted (one popped); o_Tx_Ready low from then on.
  - o_Tx_Ready reasserts on the edge that pops 0xA2.
  - Line carries 0xA1..0xA5 contiguously; o_Tx_Done pulses 5 times; o_Tx_Active is high continuously.
- Divisor change mid-frame: start 0x3C with N=4; set N=6 during DATA.
  - Current frame keeps 4-cycle bits.
  - Next queued frame uses 6-cycle bits.
- Reset mid-frame: during bit 3 of 0x81 with 2 characters queued, pulse i_Rst_L low for 1 cycle.
  - o_Tx_Serial = 1 and o_Fifo_Count = 0 immediately.
  - No further frames are sent.
  - A fresh write after release is sent normally.
- Divisor 0 with DATA_W=5: write 0x15, mode 00, i_Clks_Per_Bit=0.
  - Bits are 1 cycle each.
  - Frame is 7 cycles: 0,1,0,1,0,1,1.
